// File: rtl/cdc_hs_tx.sv
// cdc_hs_tx: source side of a 4-phase req/ack handshake carrying one word into another clock domain.
module cdc_hs_tx #(
  parameter int DATA_W  = 8,
  parameter int STAGES  = 2,
  parameter int TIMEOUT = 0
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_valid,
  output logic              o_ready,
  output logic [DATA_W-1:0] o_data,
  output logic              o_req,
  input  logic              i_ack,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_timeout
);
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] T_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  typedef enum logic [1:0] {IDLE, REQ_HI, REQ_LO} state_t;
  state_t state, state_d;
  (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] sync_q;
  logic [CW-1:0] cnt, cnt_d;
  logic [DATA_W-1:0] data_d;
  logic req_d, aborted, aborted_d, done_d, tmo_d, ack_s;
  assign ack_s   = sync_q[STAGES-1];
  assign o_busy  = state != IDLE;
  assign o_ready = rstn && state == IDLE && !ack_s;
  always_comb begin
    state_d   = state;
    data_d    = o_data;
    req_d     = o_req;
    cnt_d     = cnt;
    aborted_d = aborted;
    done_d    = 1'b0;
    tmo_d     = 1'b0;
    case (state)
      IDLE: if (i_valid && o_ready) begin
        state_d = REQ_HI;
        data_d  = i_data;
        req_d   = 1'b1;
        cnt_d   = '0;
      end
      REQ_HI: if (ack_s) begin
        state_d = REQ_LO;
        req_d   = 1'b0;
      end else if (TIMEOUT > 0 && cnt == T_LAST) begin
        state_d   = REQ_LO;
        req_d     = 1'b0;
        aborted_d = 1'b1;
        tmo_d     = 1'b1;
      end else begin
        cnt_d = cnt + 1'b1;
      end
      REQ_LO: if (!ack_s) begin
        state_d   = IDLE;
        done_d    = !aborted;
        aborted_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q    <= '0;
      state     <= IDLE;
      o_data    <= '0;
      o_req     <= 1'b0;
      o_done    <= 1'b0;
      o_timeout <= 1'b0;
      cnt       <= '0;
      aborted   <= 1'b0;
    end else begin
      sync_q    <= {sync_q[STAGES-2:0], i_ack};
      state     <= state_d;
      o_data    <= data_d;
      o_req     <= req_d;
      o_done    <= done_d;
      o_timeout <= tmo_d;
      cnt       <= cnt_d;
      aborted   <= aborted_d;
    end
  end
endmodule

// File: tb/tb_cdc_hs_tx.sv
// tb_cdc_hs_tx: randomized transfers checked against a per-transfer event timeline derived from the handshake latencies.
module tb_cdc_hs_tx;
  logic clk = 1'b0, rstn = 1'b0, i_valid = 1'b0, i_ack = 1'b0;
  logic [7:0] i_data = '0, o_data, last_data;
  logic o_ready, o_req, o_busy, o_done, o_timeout;
  int checks = 0, errors = 0;
  cdc_hs_tx #(.DATA_W(8), .STAGES(2), .TIMEOUT(16)) dut (
    .clk(clk), .rstn(rstn), .i_data(i_data), .i_valid(i_valid), .o_ready(o_ready),
    .o_data(o_data), .o_req(o_req), .i_ack(i_ack), .o_busy(o_busy), .o_done(o_done),
    .o_timeout(o_timeout)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic check_all(input string tag, input bit req, input bit busy, input bit done,
                           input bit tmo, input bit rdy, input logic [7:0] data);
    check({tag, ".req"}, 32'(o_req), 32'(req));
    check({tag, ".busy"}, 32'(o_busy), 32'(busy));
    check({tag, ".done"}, 32'(o_done), 32'(done));
    check({tag, ".timeout"}, 32'(o_timeout), 32'(tmo));
    check({tag, ".ready"}, 32'(o_ready), 32'(rdy));
    check({tag, ".data"}, 32'(o_data), 32'(data));
  endtask
  // Accept at local edge 0; ack rises before edge rise (0 = never) and falls hold edges after req drops.
  task automatic xfer(input logic [7:0] d, input int rise, input int hold);
    bit to;
    int fall, m, idle;
    to   = rise == 0 || rise >= 15;
    fall = to ? 16 : rise + 2;
    m    = fall + hold;
    idle = rise == 0 ? 17 : m + 2;
    i_valid = 1'b1;
    i_data  = d;
    for (int e = 0; e <= idle; e++) begin
      @(posedge clk);
      @(negedge clk);
      check_all("xfer", e < fall, e < idle, e == idle && !to, to && e == fall, e >= idle, d);
      if (e < idle) begin
        i_valid = 1'($urandom);
        i_data  = 8'($urandom);
      end
      if (e + 1 == rise) i_ack = 1'b1;
      if (rise != 0 && e + 1 == m) i_ack = 1'b0;
    end
    i_valid   = 1'b0;
    last_data = d;
  endtask
  task automatic gap(input int n);
    i_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
      check_all("gap", 0, 0, 0, 0, 1, last_data);
    end
  endtask
  initial begin
    last_data = '0;
    #1 check_all("rst0", 0, 0, 0, 0, 0, 8'h00);
    @(negedge clk);
    rstn = 1'b1;
    #1 check("rst0.ready_rel", 32'(o_ready), 32'd1);
    gap(1);
    xfer(8'h3C, 5, 3);
    gap(2);
    xfer(8'h11, 3, 2);
    xfer(8'h22, 4, 1);
    gap(1);
    xfer(8'h5A, 0, 0);
    xfer(8'h6B, 14, 2);
    xfer(8'h7C, 15, 2);
    gap(1);
    i_ack = 1'b1;
    @(posedge clk); @(negedge clk);
    check("stale.ready_s", 32'(o_ready), 32'd1);
    @(posedge clk); @(negedge clk);
    check("stale.ready_s1", 32'(o_ready), 32'd0);
    i_valid = 1'b1;
    i_data  = 8'h77;
    repeat (4) begin
      @(posedge clk); @(negedge clk);
      check_all("stale", 0, 0, 0, 0, 0, last_data);
    end
    i_ack = 1'b0;
    @(posedge clk); @(negedge clk);
    check_all("stale.t", 0, 0, 0, 0, 0, last_data);
    @(posedge clk); @(negedge clk);
    check_all("stale.t1", 0, 0, 0, 0, 1, last_data);
    xfer(8'h77, 3, 2);
    for (int i = 0; i < 24; i++) begin
      int r;
      int rise;
      r    = int'($urandom_range(0, 9));
      rise = r == 0 ? 0 : r == 1 ? 15 : int'($urandom_range(1, 14));
      xfer(8'($urandom), rise, int'($urandom_range(1, 5)));
      if ($urandom_range(0, 1) == 1) gap(int'($urandom_range(1, 3)));
    end
    i_valid = 1'b1;
    i_data  = 8'hA5;
    @(posedge clk); @(negedge clk);
    i_valid = 1'b0;
    check("rst1.req_pre", 32'(o_req), 32'd1);
    @(posedge clk);
    #2 rstn = 1'b0;
    #1 check_all("rst1", 0, 0, 0, 0, 0, 8'h00);
    @(negedge clk);
    rstn = 1'b1;
    #1 check("rst1.ready_rel", 32'(o_ready), 32'd1);
    last_data = 8'h00;
    gap(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/cdc_hs_tx.md
Name: cdc_hs_tx

Overview:
Source-domain transmitter for a 4-phase req/ack CDC handshake that carries a multi-bit word into another clock domain. It accepts a word through a local valid/ready interface and registers it onto a bus that stays stable for the whole handshake. It drives a glitch-free registered o_req and brings the asynchronous i_ack back through an internal multi-flop synchronizer. It pairs with a destination-side receiver that samples o_data once its synchronized copy of o_req is seen high.

Parameters:
DATA_W, 8, width of transferred word
STAGES, 2, flops in the ack synchronizer chain; min 2
TIMEOUT, 0, cycles o_req may stay high without ack before abort; 0 disables timeout

Ports:
clk  input  1  source-domain clock
rstn  input  1  reset, asynchronous, active-low
i_data  input  DATA_W  word to send
i_valid  input  1  i_data valid
o_ready  output  1  transmitter can accept a word this cycle
o_data  output  DATA_W  registered word to destination domain; held stable during handshake
o_req  output  1  request to destination; registered, no combinational path
i_ack  input  1  acknowledge from destination; asynchronous to clk
o_busy  output  1  handshake in progress (state != IDLE)
o_done  output  1  one-cycle pulse on successful completion
o_timeout  output  1  one-cycle pulse on abort

Behaviour:
- Reset (async, rstn=0):
  - state=IDLE; synchronizer flops=0; o_data=0; o_req=0; o_busy=0; o_done=0; o_timeout=0; timeout counter=0.
  - o_ready=0 while rstn=0.
- Reset mid-handshake: same values immediately. Destination must tolerate o_req dropping.
- ack_s = last flop of STAGES-deep chain clocked by clk; carries the ASYNC_REG attribute.
  - i_ack stable high before edge k gives ack_s=1 after edge k+STAGES-1.
- o_ready = (state==IDLE) && !ack_s, combinational from registers only.
  - Gating on ack_s stops a new req while a stale ack is still high.
- Accept when i_valid && o_ready at an edge. At that edge:
  - o_data<=i_data; o_req<=1; state<=REQ_HI; counter<=0.
  - o_data and o_req update on the same edge. Destination sync delay guarantees data settles first.
- FSM states:
  - IDLE: wait for accept.
  - REQ_HI: o_req=1.
    - ack_s=1 -> REQ_LO with o_req<=0.
    - Else if TIMEOUT>0 and counter==TIMEOUT-1 -> REQ_LO with o_req<=0, aborted flag<=1, o_timeout pulses in the following cycle.
    - Else counter++.
    - ack_s has priority over timeout in the same cycle.
  - REQ_LO: o_req=0; wait ack_s=0, then -> IDLE.
    - If aborted flag=0, o_done pulses in the first IDLE cycle.
    - Aborted flag is cleared on entry to IDLE.
- Latencies for a normal transfer, i_ack rising before edge k:
  - o_req=0 after edge k+STAGES.
  - i_ack falling before edge m gives state=IDLE, o_done=1 and o_ready=1 after edge m+STAGES.
- Back-to-back transfers:
  - With i_valid held, the next accept happens at the edge ending the o_done cycle.
  - o_req is therefore low for at least STAGES+1 cycles between requests.
- o_data changes only on accept and never while o_busy=1. i_data is ignored while o_ready=0.
- Counter width is $clog2(TIMEOUT+1), minimum 1. With TIMEOUT=0 the counter is unused and o_timeout stays 0.
- i_ack rising in IDLE (protocol violation): no state change; o_ready=0 until ack_s returns to 0.

Test Plan:
1. Reset: rstn=0 mid-REQ_HI with i_data=0xA5 in flight -> o_req, o_data, o_busy, o_done, o_timeout all 0 immediately. After release with i_ack=0: o_ready=1 on the first cycle.
2. Single transfer (STAGES=2): i_valid=1, i_data=0x3C at edge 0 -> o_req=1 and o_data=0x3C after edge 0. i_ack raised before edge 5 -> o_req=0 after edge 7. i_ack dropped before edge 10 -> o_done=1 for exactly one cycle after edge 12, o_ready=1.
3. Data stability: i_data toggled every cycle while o_busy=1 -> o_data stays 0x3C until the next accept.
4. Back-to-back: i_valid held with words 0x11, 0x22 and a responsive ack model -> two complete handshakes, o_data sequence 0x11 then 0x22. Second o_req rises on the edge ending the o_done cycle.
5. Timeout (TIMEOUT=16): i_ack tied 0 -> o_req high exactly 16 cycles, o_timeout one-cycle pulse, o_done never asserts, o_ready=1 again. Variant: ack_s rising in the counter==15 cycle -> normal completion, no o_timeout.
6. Stale ack: i_ack=1 while IDLE with i_valid=1 -> no accept and o_req stays 0. After i_ack=0, accept happens STAGES cycles later.
